// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use bubbles, multi-cycle
// MUL/DIV occupancy of EX, branch/jump flushes and saturating stall/flush counters.
module hazard_ctrl_mc #(
    parameter int REG_W      = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             muldiv_start,
    input  logic             jump,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             if_id_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MAX_LAT  = (LOAD_LAT > MULDIV_LAT) ? LOAD_LAT : MULDIV_LAT;
    localparam int CNT_BITS = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_STALL,
        MD_BUSY
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                load_hazard;

    assign load_hazard = id_ex_mem_read && (id_ex_rd != '0) &&
                         ((id_ex_rd == if_id_rs) || (if_id_uses_rt && (id_ex_rd == if_id_rt)));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if_id_flush   = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                if (branch_taken) begin
                    if_id_flush   = 1'b1;
                    id_ex_bubble  = 1'b1;
                    ex_mem_bubble = 1'b1;
                end else if (muldiv_start && (MULDIV_LAT > 1)) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    // The start cycle is the first of MULDIV_LAT-1 held cycles
                    if (MULDIV_LAT > 2) begin
                        state_d = MD_BUSY;
                        cnt_d   = CNT_BITS'(MULDIV_LAT - 3);
                    end
                end else if (load_hazard) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = CNT_BITS'(LOAD_LAT - 2);
                    end
                end else if (jump) begin
                    if_id_flush = 1'b1;
                end
            end
            LOAD_STALL: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                busy         = 1'b1;
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_BITS'(1);
            end
            MD_BUSY: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
                busy          = 1'b1;
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_BITS'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: two instances with different latencies and
// counter widths, compared every cycle against a stall-length reference model.
module tb_hazard_ctrl_mc;

    localparam int A_LOAD = 1;
    localparam int A_MD   = 4;
    localparam int A_CW   = 16;
    localparam int B_LOAD = 3;
    localparam int B_MD   = 1;
    localparam int B_CW   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs, rt, rd;
    logic       uses_rt, mem_read, md, jump, br;

    logic            pc_a, ifw_a, exw_a, bub_a, exb_a, fl_a, busy_a;
    logic [A_CW-1:0] sc_a, fc_a;
    logic            pc_b, ifw_b, exw_b, bub_b, exb_b, fl_b, busy_b;
    logic [B_CW-1:0] sc_b, fc_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining held cycles after the current one, stall kind, counters
    int m_left[2];
    int m_kind[2];
    int m_stall[2];
    int m_flush[2];

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.REG_W(5), .LOAD_LAT(A_LOAD), .MULDIV_LAT(A_MD), .CNT_W(A_CW)) dut_a (
        .clk(clk), .reset(reset), .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(uses_rt),
        .id_ex_mem_read(mem_read), .id_ex_rd(rd), .muldiv_start(md), .jump(jump),
        .branch_taken(br), .pc_write(pc_a), .if_id_write(ifw_a), .id_ex_write(exw_a),
        .id_ex_bubble(bub_a), .ex_mem_bubble(exb_a), .if_id_flush(fl_a), .busy(busy_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    hazard_ctrl_mc #(.REG_W(5), .LOAD_LAT(B_LOAD), .MULDIV_LAT(B_MD), .CNT_W(B_CW)) dut_b (
        .clk(clk), .reset(reset), .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(uses_rt),
        .id_ex_mem_read(mem_read), .id_ex_rd(rd), .muldiv_start(md), .jump(jump),
        .branch_taken(br), .pc_write(pc_b), .if_id_write(ifw_b), .id_ex_write(exw_b),
        .id_ex_bubble(bub_b), .ex_mem_bubble(exb_b), .if_id_flush(fl_b), .busy(busy_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_left[i]  = 0;
            m_kind[i]  = 0;
            m_stall[i] = 0;
            m_flush[i] = 0;
        end
    endtask

    // ctrl vector order: pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, busy
    task automatic modelStep(input int i, input logic [6:0] act_ctrl,
                             input logic [31:0] act_stall, input logic [31:0] act_flush);
        int         lat_ld, lat_md, max_cnt;
        logic       hz;
        logic [6:0] exp_ctrl;
        lat_ld  = (i == 0) ? A_LOAD : B_LOAD;
        lat_md  = (i == 0) ? A_MD : B_MD;
        max_cnt = (i == 0) ? ((1 << A_CW) - 1) : ((1 << B_CW) - 1);
        hz = mem_read && (rd != 0) && ((rd == rs) || (uses_rt && (rd == rt)));

        exp_ctrl = 7'b1110000;
        if (!reset && m_left[i] > 0)  exp_ctrl = (m_kind[i] == 1) ? 7'b0011001 : 7'b0000101;
        else if (br)                  exp_ctrl = 7'b1111110;
        else if (md && lat_md > 1)    exp_ctrl = 7'b0000100;
        else if (hz)                  exp_ctrl = 7'b0011000;
        else if (jump)                exp_ctrl = 7'b1110010;

        checkOutput($sformatf("ctrl_%0d", i), 32'(act_ctrl), 32'(exp_ctrl));
        checkOutput($sformatf("stall_cnt_%0d", i), act_stall, 32'(m_stall[i]));
        checkOutput($sformatf("flush_cnt_%0d", i), act_flush, 32'(m_flush[i]));

        if (reset) begin
            m_left[i]  = 0;
            m_stall[i] = 0;
            m_flush[i] = 0;
        end else begin
            if (!exp_ctrl[6] && m_stall[i] < max_cnt) m_stall[i]++;
            if (exp_ctrl[1] && m_flush[i] < max_cnt)  m_flush[i]++;
            if (m_left[i] > 0) m_left[i]--;
            else if (br) m_left[i] = 0;
            else if (md && lat_md > 1) begin
                m_kind[i] = 2;
                m_left[i] = lat_md - 2;
            end else if (hz) begin
                m_kind[i] = 1;
                m_left[i] = lat_ld - 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [4:0] s_rs, input logic [4:0] s_rt, input logic s_uses,
                                 input logic s_mr, input logic [4:0] s_rd, input logic s_md,
                                 input logic s_jmp, input logic s_br);
        @(posedge clk);
        #1;
        rs = s_rs; rt = s_rt; uses_rt = s_uses; mem_read = s_mr;
        rd = s_rd; md = s_md; jump = s_jmp; br = s_br;
        @(negedge clk);
        modelStep(0, {pc_a, ifw_a, exw_a, bub_a, exb_a, fl_a, busy_a}, 32'(sc_a), 32'(fc_a));
        modelStep(1, {pc_b, ifw_b, exw_b, bub_b, exb_b, fl_b, busy_b}, 32'(sc_b), 32'(fc_b));
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        modelReset();
        idleCycles(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rs = '0; rt = '0; rd = '0;
        uses_rt = 1'b0; mem_read = 1'b0; md = 1'b0; jump = 1'b0; br = 1'b0;
        modelReset();
        #2;
        checkOutput("rst_busy_a", 32'(busy_a), 0);
        checkOutput("rst_stall_a", 32'(sc_a), 0);
        checkOutput("rst_flush_a", 32'(fc_a), 0);
        checkOutput("rst_pc_b", 32'(pc_b), 1);
        doReset();

        $display("[TB] load x5 then use via rs");
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        idleCycles(3);
        checkOutput("lu_rs_stall_a", 32'(sc_a), 1);
        checkOutput("lu_rs_stall_b", 32'(sc_b), 3);

        $display("[TB] load x7 then use via rt");
        doReset();
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        idleCycles(3);
        checkOutput("lu_rt_stall_b", 32'(sc_b), 3);
        doReset();
        applyStimulus(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("lu_rt_unused_stall_b", 32'(sc_b), 0);

        $display("[TB] load into x0");
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("x0_stall_a", 32'(sc_a), 0);
        checkOutput("x0_stall_b", 32'(sc_b), 0);

        $display("[TB] muldiv pulse");
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        idleCycles(4);
        checkOutput("md_stall_a", 32'(sc_a), 3);
        checkOutput("md_stall_b", 32'(sc_b), 0);

        $display("[TB] branch with load hazard and muldiv");
        doReset();
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        idleCycles(1);
        checkOutput("br_flush_a", 32'(fc_a), 1);
        checkOutput("br_stall_a", 32'(sc_a), 0);
        checkOutput("br_busy_a", 32'(busy_a), 0);

        $display("[TB] reset during muldiv stall");
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        idleCycles(1);
        @(posedge clk);
        #1;
        checkOutput("md2_busy_a", 32'(busy_a), 1);
        reset = 1'b1;
        #1;
        checkOutput("mdrst_busy_a", 32'(busy_a), 0);
        checkOutput("mdrst_stall_a", 32'(sc_a), 0);
        checkOutput("mdrst_pc_a", 32'(pc_a), 1);
        modelReset();
        idleCycles(1);
        reset = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idleCycles(1);
        checkOutput("mdrst_flush_a", 32'(fc_a), 1);

        $display("[TB] randomized traffic");
        doReset();
        for (int n = 0; n < 800; n++) begin
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) < 1), ($urandom_range(0, 9) < 2),
                          ($urandom_range(0, 9) < 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
